skid_crd_pipe: RTL and testbench

- Credit-controlled AXI-Stream buffer that generalises the 2-entry credit skid.
- Parametrised data width, buffer depth, and number of register stages between the input handshake and buffer storage.
- in_tready is driven only from a credit counter register, so there is no combinational path from out_tready to in_tready.
- Used between pipeline regions where long routes need several register slices on the data path.

---
 rtl/skid_crd_pkg.sv | 16 +
 rtl/skid_crd_delay.sv | 40 ++++
 rtl/skid_crd_pipe.sv | 139 +++++++++++++
 tb/tb_skid_crd_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_crd_pkg.sv
// Shared sizing helpers and parameter bounds for the credit-controlled skid pipe.
package skid_crd_pkg;

   localparam int MAX_DEPTH = 64;
   localparam int MAX_PIPE  = 4;

   function automatic int cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Credits available out of reset: one per storage entry.
   function automatic int rst_crd(input int depth);
      return depth;
   endfunction

endpackage

// File: rtl/skid_crd_delay.sv
// PIPE-stage valid/payload shift line between the input handshake and buffer write.
// PIPE=0 collapses to wires; payload stages are not reset, valids clear synchronously.
module skid_crd_delay #(
   parameter int  PIPE = 1,
   parameter type T    = logic
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vld,
   input  T     i_dat,
   output logic o_vld,
   output T     o_dat
);

   if (PIPE == 0) begin : g_wire
      assign o_vld = i_vld;
      assign o_dat = i_dat;
   end else begin : g_line
      logic [PIPE-1:0] r_vld;
      T                r_dat [PIPE];

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < PIPE; i++) r_vld[i] <= r_vld[i-1];
         end
      end

      always_ff @(posedge i_clk) begin
         r_dat[0] <= i_dat;
         for (int i = 1; i < PIPE; i++) r_dat[i] <= r_dat[i-1];
      end

      assign o_vld = r_vld[PIPE-1];
      assign o_dat = r_dat[PIPE-1];
   end

endmodule

// File: rtl/skid_crd_pipe.sv
// Credit-controlled AXI-Stream buffer: delay line feeding a circular buffer, in_tready from credits only.
// Optional tlast/pkt_cnt support when SKID_CRD_PIPE_TLAST_EN is defined.
module skid_crd_pipe
   import skid_crd_pkg::*;
#(
   parameter  int NB    = 40,
   parameter  int DEPTH = 4,
   parameter  int PIPE  = 1,
   localparam int CW    = cw(DEPTH)
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [NB-1:0] in_tdata,
   input  logic          in_tvalid,
   output logic          in_tready,
   output logic [NB-1:0] out_tdata,
   output logic          out_tvalid,
   input  logic          out_tready,
   output logic [CW-1:0] crd_cnt,
   output logic [CW-1:0] fifo_level
`ifdef SKID_CRD_PIPE_TLAST_EN
  ,input  logic          in_tlast,
   output logic          out_tlast,
   output logic [CW-1:0] pkt_cnt
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("skid_crd_pipe: DEPTH must be in 2..64");
   end
   if (PIPE < 0 || PIPE > MAX_PIPE) begin : g_bad_pipe
      $error("skid_crd_pipe: PIPE must be in 0..4");
   end

   // Beat width tracks NB, so the type is declared here rather than in the package.
`ifdef SKID_CRD_PIPE_TLAST_EN
   typedef struct packed { logic [NB-1:0] data; logic last; } beat_t;
`else
   typedef struct packed { logic [NB-1:0] data; } beat_t;
`endif

   logic [CW-1:0] r_crd;
   logic [CW-1:0] r_lvl;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   beat_t         r_mem [DEPTH];

   logic  w_wr;
   logic  w_rd;
   logic  w_bwr;
   beat_t w_in;
   beat_t w_bdat;
   beat_t w_head;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_tready  = (r_crd != '0);
   assign out_tvalid = (r_lvl != '0);
   assign w_wr       = in_tvalid & in_tready;
   assign w_rd       = out_tvalid & out_tready;

   always_comb begin
      w_in      = '0;
      w_in.data = in_tdata;
`ifdef SKID_CRD_PIPE_TLAST_EN
      w_in.last = in_tlast;
`endif
   end

   skid_crd_delay #(
      .PIPE (PIPE),
      .T    (beat_t)
   ) u_delay (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_vld   (w_wr),
      .i_dat   (w_in),
      .o_vld   (w_bwr),
      .o_dat   (w_bdat)
   );

   // A credit leaves on acceptance and only returns when storage drains,
   // so the buffer can never be written while full.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_crd <= CW'(rst_crd(DEPTH));
      end else if (w_wr && !w_rd) begin
         r_crd <= r_crd - CW'(1);
      end else if (w_rd && !w_wr) begin
         r_crd <= r_crd + CW'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_lvl  <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_bwr) r_wptr <= nxt(r_wptr);
         if (w_rd)  r_rptr <= nxt(r_rptr);
         if (w_bwr && !w_rd)      r_lvl <= r_lvl + CW'(1);
         else if (w_rd && !w_bwr) r_lvl <= r_lvl - CW'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (w_bwr) r_mem[r_wptr] <= w_bdat;
   end

   assign w_head     = r_mem[r_rptr];
   assign out_tdata  = w_head.data;
   assign crd_cnt    = r_crd;
   assign fifo_level = r_lvl;

`ifdef SKID_CRD_PIPE_TLAST_EN
   logic [CW-1:0] r_pkt;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_pkt <= '0;
      end else begin
         case ({w_bwr & w_bdat.last, w_rd & w_head.last})
            2'b10:   r_pkt <= r_pkt + CW'(1);
            2'b01:   r_pkt <= r_pkt - CW'(1);
            default: r_pkt <= r_pkt;
         endcase
      end
   end

   assign out_tlast = w_head.last;
   assign pkt_cnt   = r_pkt;
`endif

endmodule

// File: tb/tb_skid_crd_pipe.sv
// Directed bench: vector table on DEPTH=4/PIPE=1, throughput, mid-operation reset, optional tlast.
module tb_skid_crd_pipe;

   logic aclk = 1'b0;
   logic rst_n;
   always #5 aclk = ~aclk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // A: DEPTH=4 PIPE=1 (vector table)
   logic [39:0] a_dat, a_odat;
   logic        a_vld, a_rdy, a_ov, a_ordy;
   logic [2:0]  a_crd, a_lvl;
   // B: DEPTH=3 PIPE=1, C: DEPTH=2 PIPE=1 (throughput)
   logic [39:0] b_dat, b_odat, c_dat, c_odat;
   logic        b_vld, b_rdy, b_ov, b_ordy, c_vld, c_rdy, c_ov, c_ordy;
   logic [1:0]  b_crd, b_lvl, c_crd, c_lvl;
   // D: DEPTH=4 PIPE=2 (mid-operation reset)
   logic [39:0] d_dat, d_odat;
   logic        d_vld, d_rdy, d_ov, d_ordy;
   logic [2:0]  d_crd, d_lvl;
`ifdef SKID_CRD_PIPE_TLAST_EN
   logic       a_tl, b_tl, c_tl, d_tl;
   logic [2:0] a_pk, d_pk;
   logic [1:0] b_pk, c_pk;
`endif

   skid_crd_pipe #(.NB(40), .DEPTH(4), .PIPE(1)) u_a (
      .aclk(aclk), .aresetn(rst_n), .in_tdata(a_dat), .in_tvalid(a_vld), .in_tready(a_rdy),
      .out_tdata(a_odat), .out_tvalid(a_ov), .out_tready(a_ordy), .crd_cnt(a_crd), .fifo_level(a_lvl)
`ifdef SKID_CRD_PIPE_TLAST_EN
     ,.in_tlast(1'b0), .out_tlast(a_tl), .pkt_cnt(a_pk)
`endif
   );

   skid_crd_pipe #(.NB(40), .DEPTH(3), .PIPE(1)) u_b (
      .aclk(aclk), .aresetn(rst_n), .in_tdata(b_dat), .in_tvalid(b_vld), .in_tready(b_rdy),
      .out_tdata(b_odat), .out_tvalid(b_ov), .out_tready(b_ordy), .crd_cnt(b_crd), .fifo_level(b_lvl)
`ifdef SKID_CRD_PIPE_TLAST_EN
     ,.in_tlast(1'b0), .out_tlast(b_tl), .pkt_cnt(b_pk)
`endif
   );

   skid_crd_pipe #(.NB(40), .DEPTH(2), .PIPE(1)) u_c (
      .aclk(aclk), .aresetn(rst_n), .in_tdata(c_dat), .in_tvalid(c_vld), .in_tready(c_rdy),
      .out_tdata(c_odat), .out_tvalid(c_ov), .out_tready(c_ordy), .crd_cnt(c_crd), .fifo_level(c_lvl)
`ifdef SKID_CRD_PIPE_TLAST_EN
     ,.in_tlast(1'b0), .out_tlast(c_tl), .pkt_cnt(c_pk)
`endif
   );

   skid_crd_pipe #(.NB(40), .DEPTH(4), .PIPE(2)) u_d (
      .aclk(aclk), .aresetn(rst_n), .in_tdata(d_dat), .in_tvalid(d_vld), .in_tready(d_rdy),
      .out_tdata(d_odat), .out_tvalid(d_ov), .out_tready(d_ordy), .crd_cnt(d_crd), .fifo_level(d_lvl)
`ifdef SKID_CRD_PIPE_TLAST_EN
     ,.in_tlast(1'b0), .out_tlast(d_tl), .pkt_cnt(d_pk)
`endif
   );

`ifdef SKID_CRD_PIPE_TLAST_EN
   // E: DEPTH=8 PIPE=1 with tlast
   logic [39:0] e_dat, e_odat;
   logic        e_vld, e_rdy, e_ov, e_ordy, e_last, e_tl;
   logic [3:0]  e_crd, e_lvl, e_pk;
   skid_crd_pipe #(.NB(40), .DEPTH(8), .PIPE(1)) u_e (
      .aclk(aclk), .aresetn(rst_n), .in_tdata(e_dat), .in_tvalid(e_vld), .in_tready(e_rdy),
      .out_tdata(e_odat), .out_tvalid(e_ov), .out_tready(e_ordy), .crd_cnt(e_crd), .fifo_level(e_lvl),
      .in_tlast(e_last), .out_tlast(e_tl), .pkt_cnt(e_pk)
   );
`endif

   typedef struct {
      logic        vld;
      logic [39:0] dat;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic [39:0] e_dat;
      logic [2:0]  e_crd;
      logic [2:0]  e_lvl;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [39:0] d, input logic r,
                               input logic er, input logic eo, input logic [39:0] ed,
                               input int ec, input int el);
      vec_t t;
      t.vld = v; t.dat = d; t.ordy = r;
      t.e_rdy = er; t.e_ov = eo; t.e_dat = ed; t.e_crd = 3'(ec); t.e_lvl = 3'(el);
      return t;
   endfunction

   function automatic logic [39:0] dk(input int k);
      return 40'hA0_0000_0000 | 40'(k);
   endfunction

   localparam logic [39:0] P = 40'h01_0203_0405;

   vec_t tbl [15];
   int   nacc, rx, bad;
   logic acc;

   initial begin
      // expected outputs are the state after the edge that consumes the row's inputs
      tbl[0]  = mk(1, P,      1,  1, 0, '0,     3, 0);
      tbl[1]  = mk(0, '0,     1,  1, 1, P,      3, 1);
      tbl[2]  = mk(0, '0,     1,  1, 0, '0,     4, 0);
      tbl[3]  = mk(1, dk(0),  0,  1, 0, '0,     3, 0);
      tbl[4]  = mk(1, dk(1),  0,  1, 1, dk(0),  2, 1);
      tbl[5]  = mk(1, dk(2),  0,  1, 1, dk(0),  1, 2);
      tbl[6]  = mk(1, dk(3),  0,  0, 1, dk(0),  0, 3);
      tbl[7]  = mk(1, dk(4),  0,  0, 1, dk(0),  0, 4);
      tbl[8]  = mk(1, dk(4),  0,  0, 1, dk(0),  0, 4);
      tbl[9]  = mk(1, dk(4),  1,  1, 1, dk(1),  1, 3);
      tbl[10] = mk(1, dk(4),  1,  1, 1, dk(2),  1, 2);
      tbl[11] = mk(1, dk(5),  1,  1, 1, dk(3),  1, 2);
      tbl[12] = mk(0, '0,     1,  1, 1, dk(4),  2, 2);
      tbl[13] = mk(0, '0,     1,  1, 1, dk(5),  3, 1);
      tbl[14] = mk(0, '0,     1,  1, 0, '0,     4, 0);

      rst_n = 1'b0;
      a_vld = 0; a_dat = '0; a_ordy = 0;
      b_vld = 0; b_dat = '0; b_ordy = 0;
      c_vld = 0; c_dat = '0; c_ordy = 0;
      d_vld = 0; d_dat = '0; d_ordy = 0;
`ifdef SKID_CRD_PIPE_TLAST_EN
      e_vld = 0; e_dat = '0; e_ordy = 0; e_last = 0;
`endif
      repeat (3) @(negedge aclk);
      rst_n = 1'b1;

      chk("rst_in_tready", a_rdy, 1);
      chk("rst_out_tvalid", a_ov, 0);
      chk("rst_crd_cnt", a_crd, 4);
      chk("rst_fifo_level", a_lvl, 0);

      for (int i = 0; i < 15; i++) begin
         a_vld = tbl[i].vld; a_dat = tbl[i].dat; a_ordy = tbl[i].ordy;
         @(negedge aclk);
         chk($sformatf("v%0d_in_tready", i), a_rdy, tbl[i].e_rdy);
         chk($sformatf("v%0d_out_tvalid", i), a_ov, tbl[i].e_ov);
         if (tbl[i].e_ov) chk($sformatf("v%0d_out_tdata", i), a_odat, tbl[i].e_dat);
         chk($sformatf("v%0d_crd_cnt", i), a_crd, tbl[i].e_crd);
         chk($sformatf("v%0d_fifo_level", i), a_lvl, tbl[i].e_lvl);
      end
      a_vld = 0; a_ordy = 0;

      // DEPTH=3, PIPE=1: one beat per cycle sustained
      b_vld = 1; b_ordy = 1; b_dat = '0; nacc = 0; rx = 0; bad = 0;
      for (int k = 0; k < 100; k++) begin
         acc = b_rdy;
         if (b_ov) begin
            if (b_odat != 40'(rx)) bad++;
            rx++;
         end
         @(negedge aclk);
         if (acc) begin nacc++; b_dat = b_dat + 40'd1; end
      end
      b_vld = 0;
      chk("d3_accepted_100", nacc, 100);
      chk("d3_order", bad, 0);
      chk("d3_received_min", (rx >= 95), 1);

      // DEPTH=2, PIPE=1: credit round trip limits to 2 beats per 3 cycles
      c_vld = 1; c_ordy = 1; c_dat = '0; nacc = 0; rx = 0; bad = 0;
      for (int k = 0; k < 99; k++) begin
         acc = c_rdy;
         if (c_ov) begin
            if (c_odat != 40'(rx)) bad++;
            rx++;
         end
         @(negedge aclk);
         if (acc) begin nacc++; c_dat = c_dat + 40'd1; end
      end
      c_vld = 0;
      chk("d2_accepted_66", nacc, 66);
      chk("d2_order", bad, 0);

      // DEPTH=4, PIPE=2: reset with 2 beats in the line and 2 in storage
      d_ordy = 0; d_vld = 1;
      for (int k = 0; k < 4; k++) begin
         d_dat = 40'h11 + 40'(k);
         @(negedge aclk);
      end
      d_vld = 0;
      chk("prerst_crd_cnt", d_crd, 0);
      chk("prerst_fifo_level", d_lvl, 2);
      chk("prerst_in_tready", d_rdy, 0);
      rst_n = 1'b0;
      @(negedge aclk);
      rst_n = 1'b1;
      d_ordy = 1;
      chk("midrst_crd_cnt", d_crd, 4);
      chk("midrst_fifo_level", d_lvl, 0);
      chk("midrst_out_tvalid", d_ov, 0);
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge aclk);
         if (d_ov) bad++;
      end
      chk("midrst_no_output", bad, 0);
      chk("midrst_crd_after", d_crd, 4);
      d_ordy = 0;

`ifdef SKID_CRD_PIPE_TLAST_EN
      // two 3-beat packets while stalled, then drain
      e_ordy = 0; e_vld = 1;
      for (int k = 0; k < 6; k++) begin
         e_dat = 40'(k); e_last = (k == 2 || k == 5);
         @(negedge aclk);
      end
      e_vld = 0; e_last = 0;
      @(negedge aclk);
      chk("tl_pkt_cnt_2", e_pk, 2);
      chk("tl_fifo_level", e_lvl, 6);
      e_ordy = 1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("tl_b%0d_valid", k), e_ov, 1);
         chk($sformatf("tl_b%0d_data", k), e_odat, 40'(k));
         chk($sformatf("tl_b%0d_last", k), e_tl, (k == 2 || k == 5));
         @(negedge aclk);
      end
      chk("tl_pkt_cnt_0", e_pk, 0);
      chk("tl_empty", e_ov, 0);
      e_ordy = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
